// File: rtl/piso8_tx_if.sv
// Load handshake and serial output bundle for piso8_tx.
// master: word source / serial sink; slave: the transmitter.
interface piso8_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output ser_out,
        output ser_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso8_tx.sv
// piso8_tx: parallel-in/serial-out transmitter, one bit per enabled clock.
// Optional macro PARITY_EN appends an XOR parity bit after the data bits.
module piso8_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic      Clk,
    input  logic      Res,
    input  logic      En,
    piso8_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SHIFT
    } state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             valid_q;
    logic             sout_q;
    logic             sout_d;
    logic             first_d;
    logic             done_q;
`ifdef PARITY_EN
    logic             par_q;
`endif

    // Shift direction: next register contents, bit shown after the shift,
    // and the bit shown first when a word is captured.
    always_comb begin
        shreg_d = shreg_q;
        sout_d  = 1'b0;
        first_d = 1'b0;
        if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            sout_d  = shreg_q[WIDTH-2];
            first_d = bus.load_data[WIDTH-1];
        end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            sout_d  = shreg_q[1];
            first_d = bus.load_data[0];
        end
    end

    // Transmit FSM; every output is a register updated with the state.
    always_ff @(posedge Clk) begin
        if (Res) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        state_q <= SHIFT;
                        shreg_q <= bus.load_data;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        sout_q  <= first_d;
`ifdef PARITY_EN
                        par_q   <= ^bus.load_data;
`endif
                    end
                end
                SHIFT: begin
                    if (En) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
`ifdef PARITY_EN
                            state_q <= PARITY;
                            sout_q  <= par_q;
`else
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            sout_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            sout_q <= sout_d;
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (En) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        sout_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    sout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.ser_valid  = valid_q;
    assign bus.ser_out    = sout_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_piso8_tx.sv
// Directed bench for piso8_tx: LSB-first instance plus an MSB-first instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_piso8_tx;
    logic Clk;
    logic Res;
    logic En;
    int   ncmp;
    int   nerr;
    logic [7:0] w;

    piso8_tx_if #(.WIDTH(8)) bus ();
    piso8_tx_if #(.WIDTH(8)) bus_m ();

    piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .Clk(Clk),
        .Res(Res),
        .En (En),
        .bus(bus.slave)
    );

    piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .Clk(Clk),
        .Res(Res),
        .En (En),
        .bus(bus_m.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic dn);
        chk({tag, ".valid"}, {7'd0, bus.ser_valid}, 8'd0);
        chk({tag, ".busy"}, {7'd0, bus.busy}, 8'd0);
        chk({tag, ".ready"}, {7'd0, bus.load_ready}, 8'd1);
        chk({tag, ".done"}, {7'd0, bus.done}, {7'd0, dn});
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        Res = 1'b1;
        En = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data = 8'h00;
        bus_m.load_valid = 1'b0;
        bus_m.load_data = 8'h00;
        tick();
        tick();
        chk_idle("reset", 1'b0);
        chk("reset.sout", {7'd0, bus.ser_out}, 8'd0);
        Res = 1'b0;

        // Word A5 with En held high; En at the load edge must not shift.
        w = 8'hA5;
        bus.load_valid = 1'b1;
        bus.load_data = w;
        En = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        chk("a5.ready", {7'd0, bus.load_ready}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5.bit%0d", i), {7'd0, bus.ser_out}, {7'd0, w[i]});
            chk($sformatf("a5.v%0d", i), {7'd0, bus.ser_valid}, 8'd1);
            chk($sformatf("a5.d%0d", i), {7'd0, bus.done}, 8'd0);
            tick();
        end
        chk_idle("a5.end", 1'b1);
        tick();
        chk_idle("a5.after", 1'b0);

        // Word 81 with En alternating: each bit stays two cycles.
        w = 8'h81;
        En = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data = w;
        tick();
        bus.load_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("81.bit%0d", k), {7'd0, bus.ser_out},
                {7'd0, w[k>>1]});
            chk($sformatf("81.d%0d", k), {7'd0, bus.done}, 8'd0);
            En = (k % 2 == 1);
            tick();
        end
        chk_idle("81.end", 1'b1);
        En = 1'b0;
        tick();
        chk_idle("81.after", 1'b0);

        // load_valid held high: 01 then FF, reload in the done cycle.
        En = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data = 8'h01;
        tick();
        w = 8'h01;
        bus.load_data = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("01.bit%0d", i), {7'd0, bus.ser_out}, {7'd0, w[i]});
            tick();
        end
        chk_idle("b2b.gap", 1'b1);
        tick();
        bus.load_valid = 1'b0;
        w = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ff.bit%0d", i), {7'd0, bus.ser_out}, {7'd0, w[i]});
            chk($sformatf("ff.v%0d", i), {7'd0, bus.ser_valid}, 8'd1);
            tick();
        end
        chk_idle("ff.end", 1'b1);
        tick();

        // Mid-word load of 3C is ignored.
        w = 8'hA5;
        bus.load_valid = 1'b1;
        bus.load_data = w;
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                bus.load_valid = 1'b1;
                bus.load_data = 8'h3C;
            end
            if (i == 6) bus.load_valid = 1'b0;
            chk($sformatf("ign.bit%0d", i), {7'd0, bus.ser_out}, {7'd0, w[i]});
            chk($sformatf("ign.rdy%0d", i), {7'd0, bus.load_ready}, 8'd0);
            tick();
        end
        chk_idle("ign.end", 1'b1);
        tick();
        chk_idle("ign.after", 1'b0);

        // Reset for two cycles in the middle of a word.
        bus.load_valid = 1'b1;
        bus.load_data = 8'hA5;
        tick();
        bus.load_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rst.busy_pre", {7'd0, bus.busy}, 8'd1);
        Res = 1'b1;
        tick();
        tick();
        Res = 1'b0;
        chk_idle("rst.mid", 1'b0);
        chk("rst.sout", {7'd0, bus.ser_out}, 8'd0);
        tick();
        chk_idle("rst.en_idle", 1'b0);

`ifdef PARITY_EN
        // Parity: 07 -> par 1, 03 -> par 0.
        w = 8'h07;
        bus.load_valid = 1'b1;
        bus.load_data = w;
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("p07.bit%0d", i), {7'd0, bus.ser_out}, {7'd0, w[i]});
            tick();
        end
        chk("p07.par", {7'd0, bus.ser_out}, 8'd1);
        chk("p07.pv", {7'd0, bus.ser_valid}, 8'd1);
        chk("p07.pd", {7'd0, bus.done}, 8'd0);
        tick();
        chk_idle("p07.end", 1'b1);
        tick();
        w = 8'h03;
        bus.load_valid = 1'b1;
        bus.load_data = w;
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("p03.bit%0d", i), {7'd0, bus.ser_out}, {7'd0, w[i]});
            tick();
        end
        chk("p03.par", {7'd0, bus.ser_out}, 8'd0);
        chk("p03.pv", {7'd0, bus.ser_valid}, 8'd1);
        tick();
        chk_idle("p03.end", 1'b1);
        tick();
`endif

        // MSB-first instance: A5 from bit 7 down.
        w = 8'hA5;
        bus_m.load_valid = 1'b1;
        bus_m.load_data = w;
        tick();
        bus_m.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("msb.bit%0d", i), {7'd0, bus_m.ser_out},
                {7'd0, w[7-i]});
            chk($sformatf("msb.v%0d", i), {7'd0, bus_m.ser_valid}, 8'd1);
            tick();
        end
`ifdef PARITY_EN
        chk("msb.par", {7'd0, bus_m.ser_out}, 8'd0);
        tick();
`endif
        chk("msb.done", {7'd0, bus_m.done}, 8'd1);
        chk("msb.valid", {7'd0, bus_m.ser_valid}, 8'd0);
        chk("msb.ready", {7'd0, bus_m.load_ready}, 8'd1);
        tick();
        chk("msb.done_off", {7'd0, bus_m.done}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
